// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter.
//   MAIN_IDX  : requester index of the main pipeline (coprocessors follow it)
//   RD_W      : register index width
//   DATA_W    : write data width
//   idx_width : ceil(log2(n)), never less than 1, used to size WB_SRC and the
//               round-robin pointer
package wb_arbiter_pkg;

    localparam int MAIN_IDX = 0;
    localparam int RD_W     = 5;
    localparam int DATA_W   = 32;

    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr.sv
// Combinational round-robin picker.
// Ports:
//   req       : per-requester request vector
//   ptr       : index where the upward scan starts (wraps N-1 -> 0)
//   en        : when low no grant is issued
//   grant     : one-hot grant, or zero
//   grant_idx : index of the granted requester (0 when nothing granted)
module rr_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   ptr,
    input  logic                      en,
    output logic [N-1:0]              grant,
    output logic [idx_width(N)-1:0]   grant_idx
);

    localparam int W = idx_width(N);

    logic         found;
    logic [W-1:0] idx;

    function automatic logic [W-1:0] slot(input logic [W-1:0] base, input int offset);
        int s;
        s = (int'(base) + offset) % N;
        return W'(s);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = slot(ptr, k);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges register-file write requests from the main
// pipeline (index 0) and COP_NUMS coprocessors into one registered write
// beat, granting round-robin with a one-entry output slot.
// Ports:
//   CLK, RST (async, active-low), FLUSH (sync, active-high)
//   REQ_VALID/REQ_RD/REQ_DATA : per-requester requests, packed slices
//   REQ_READY                 : per-requester accept (one-hot or zero)
//   WB_VALID/WB_RD/WB_DATA    : pending register-file write beat
//   WB_SRC                    : requester that produced the pending beat
//   WB_READY                  : register file takes the pending beat
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int COP_NUMS = 1,
    parameter int PNUMS    = COP_NUMS + 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          FLUSH,
    input  logic [PNUMS-1:0]              REQ_VALID,
    input  logic [RD_W*PNUMS-1:0]         REQ_RD,
    input  logic [DATA_W*PNUMS-1:0]       REQ_DATA,
    output logic [PNUMS-1:0]              REQ_READY,
    output logic                          WB_VALID,
    output logic [RD_W-1:0]               WB_RD,
    output logic [DATA_W-1:0]             WB_DATA,
    output logic [idx_width(PNUMS)-1:0]   WB_SRC,
    input  logic                          WB_READY
);

    localparam int SRC_W = idx_width(PNUMS);

    logic [SRC_W-1:0]  ptr;
    logic [SRC_W-1:0]  ptr_next;
    logic [SRC_W-1:0]  grant_idx;
    logic [PNUMS-1:0]  grant;
    logic              slot_free;
    logic              arb_en;
    logic              xfer;
    logic [RD_W-1:0]   sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic [RD_W-1:0]   rd_slot   [PNUMS];
    logic [DATA_W-1:0] data_slot [PNUMS];

    for (genvar i = 0; i < PNUMS; i++) begin : g_unpack
        assign rd_slot[i]   = REQ_RD[RD_W*i +: RD_W];
        assign data_slot[i] = REQ_DATA[DATA_W*i +: DATA_W];
    end

    // The slot is free when empty or being drained this cycle; RST gates the
    // grant so REQ_READY stays low throughout reset.
    assign slot_free = !WB_VALID || WB_READY;
    assign arb_en    = RST && slot_free && !FLUSH;

    rr_arbiter #(
        .N(PNUMS)
    ) u_rr (
        .req       (REQ_VALID),
        .ptr       (ptr),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign REQ_READY = grant;
    assign xfer      = |grant;
    assign sel_rd    = rd_slot[grant_idx];
    assign sel_data  = data_slot[grant_idx];

    always_comb begin
        ptr_next = grant_idx + SRC_W'(1);
        if (int'(grant_idx) == PNUMS - 1) begin
            ptr_next = '0;
        end
    end

    // Output beat register: a grant always coincides with a free slot, so a
    // new transfer replaces (drains) whatever was pending. Writes to r0 are
    // accepted and dropped, leaving the slot empty.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            WB_VALID <= 1'b0;
            WB_RD    <= '0;
            WB_DATA  <= '0;
            WB_SRC   <= '0;
            ptr      <= SRC_W'(MAIN_IDX);
        end else if (FLUSH) begin
            WB_VALID <= 1'b0;
            WB_RD    <= '0;
            WB_DATA  <= '0;
            WB_SRC   <= '0;
            ptr      <= SRC_W'(MAIN_IDX);
        end else if (xfer) begin
            ptr      <= ptr_next;
            WB_VALID <= (sel_rd != '0);
            if (sel_rd != '0) begin
                WB_RD   <= sel_rd;
                WB_DATA <= sel_data;
                WB_SRC  <= grant_idx;
            end
        end else if (WB_READY) begin
            WB_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int COP = 3;
    localparam int P   = COP + 1;

    logic            CLK = 1'b0;
    logic            RST;
    logic            FLUSH;
    logic [P-1:0]    REQ_VALID;
    logic [5*P-1:0]  REQ_RD;
    logic [32*P-1:0] REQ_DATA;
    logic [P-1:0]    REQ_READY;
    logic            WB_VALID;
    logic [4:0]      WB_RD;
    logic [31:0]     WB_DATA;
    logic [1:0]      WB_SRC;
    logic            WB_READY;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_src;
    int          m_ptr;

    wb_arbiter #(.COP_NUMS(COP), .PNUMS(P)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .FLUSH     (FLUSH),
        .REQ_VALID (REQ_VALID),
        .REQ_RD    (REQ_RD),
        .REQ_DATA  (REQ_DATA),
        .REQ_READY (REQ_READY),
        .WB_VALID  (WB_VALID),
        .WB_RD     (WB_RD),
        .WB_DATA   (WB_DATA),
        .WB_SRC    (WB_SRC),
        .WB_READY  (WB_READY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic edge1();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [4:0] rd, input logic [31:0] d);
        REQ_VALID[i]        = v;
        REQ_RD[5*i +: 5]    = rd;
        REQ_DATA[32*i +: 32] = d;
    endtask

    task automatic clear_inputs();
        REQ_VALID = '0;
        REQ_RD    = '0;
        REQ_DATA  = '0;
        WB_READY  = 1'b1;
        FLUSH     = 1'b0;
    endtask

    task automatic do_flush();
        FLUSH = 1'b1;
        edge1();
        FLUSH = 1'b0;
    endtask

    // Round-robin rule: no grant when reset/flush or slot occupied and not
    // draining; otherwise first valid index scanning up from the pointer.
    function automatic int model_pick();
        if (!RST || FLUSH || (m_valid && !WB_READY)) return -1;
        for (int k = 0; k < P; k++) begin
            int idx = (m_ptr + k) % P;
            if (REQ_VALID[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step();
        int g;
        g = model_pick();
        if (!RST || FLUSH) begin
            m_valid = 0; m_rd = '0; m_data = '0; m_src = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % P;
            if (REQ_RD[5*g +: 5] != 5'd0) begin
                m_valid = 1;
                m_rd    = REQ_RD[5*g +: 5];
                m_data  = REQ_DATA[32*g +: 32];
                m_src   = g;
            end else begin
                m_valid = 0;
            end
        end else if (WB_READY) begin
            m_valid = 0;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_rdy;
        RST = 1'b1;
        clear_inputs();
        REQ_VALID = '1;
        for (int i = 0; i < P; i++) set_req(i, 1'b1, 5'(i + 1), 32'(i));
        #2 RST = 1'b0;
        #1;
        total++;
        if ({WB_VALID, WB_RD, WB_DATA, WB_SRC} !== 40'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b rd=%0d data=%h src=%0d, want all zero", WB_VALID, WB_RD, WB_DATA, WB_SRC);
        end
        total++;
        if (REQ_READY !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ready: got %b want 0000", REQ_READY);
        end
        edge1();
        total++;
        if (WB_VALID !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_valid: got %b want 0", WB_VALID);
        end
        RST = 1'b1;
        #1;
        exp_rdy = 4'b0001;
        total++;
        if (REQ_READY !== exp_rdy) begin
            bad++;
            $display("FAIL post_reset_ready: got %b want %b", REQ_READY, exp_rdy);
        end
        edge1();
        total++;
        if ({WB_VALID, WB_RD, WB_SRC} !== {1'b1, 5'd1, 2'd0}) begin
            bad++;
            $display("FAIL first_grant: got v=%b rd=%0d src=%0d, want v=1 rd=1 src=0", WB_VALID, WB_RD, WB_SRC);
        end
        clear_inputs();
        do_flush();
    endtask

    task automatic test_two_requesters();
        clear_inputs();
        do_flush();
        set_req(0, 1'b1, 5'd3, 32'h11);
        set_req(1, 1'b1, 5'd4, 32'h22);
        #1;
        total++;
        if (REQ_READY !== 4'b0001) begin
            bad++;
            $display("FAIL two_req_ready_main: got %b want 0001", REQ_READY);
        end
        edge1();
        total++;
        if ({WB_VALID, WB_RD, WB_DATA, WB_SRC} !== {1'b1, 5'd3, 32'h11, 2'd0}) begin
            bad++;
            $display("FAIL two_req_main_beat: got v=%b rd=%0d data=%h src=%0d, want 1/3/11/0", WB_VALID, WB_RD, WB_DATA, WB_SRC);
        end
        set_req(0, 1'b0, 5'd0, 32'h0);
        #1;
        total++;
        if (REQ_READY !== 4'b0010) begin
            bad++;
            $display("FAIL two_req_ready_cop: got %b want 0010", REQ_READY);
        end
        edge1();
        total++;
        if ({WB_VALID, WB_RD, WB_DATA, WB_SRC} !== {1'b1, 5'd4, 32'h22, 2'd1}) begin
            bad++;
            $display("FAIL two_req_cop_beat: got v=%b rd=%0d data=%h src=%0d, want 1/4/22/1", WB_VALID, WB_RD, WB_DATA, WB_SRC);
        end
        clear_inputs();
        edge1();
        total++;
        if (WB_VALID !== 1'b0) begin
            bad++;
            $display("FAIL drain_no_new: got valid %b want 0", WB_VALID);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] one;
        one = 4'b0001;
        clear_inputs();
        do_flush();
        for (int i = 0; i < P; i++) set_req(i, 1'b1, 5'(i + 8), 32'(i * 256 + 7));
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (REQ_READY !== (one << (c % P))) begin
                bad++;
                $display("FAIL rr_ready[%0d]: got %b want %b", c, REQ_READY, one << (c % P));
            end
            edge1();
            total++;
            if ({WB_VALID, WB_SRC, WB_RD} !== {1'b1, 2'(c % P), 5'((c % P) + 8)}) begin
                bad++;
                $display("FAIL rr_src[%0d]: got v=%b src=%0d rd=%0d, want v=1 src=%0d rd=%0d", c, WB_VALID, WB_SRC, WB_RD, c % P, (c % P) + 8);
            end
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        clear_inputs();
        do_flush();
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        edge1();
        set_req(0, 1'b1, 5'd6, 32'h66);
        WB_READY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (REQ_READY !== 4'b0000) begin
                bad++;
                $display("FAIL stall_ready[%0d]: got %b want 0000", c, REQ_READY);
            end
            edge1();
            total++;
            if ({WB_VALID, WB_RD, WB_DATA, WB_SRC} !== {1'b1, 5'd5, 32'hDEADBEEF, 2'd0}) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got v=%b rd=%0d data=%h src=%0d, want 1/5/deadbeef/0", c, WB_VALID, WB_RD, WB_DATA, WB_SRC);
            end
        end
        WB_READY = 1'b1;
        #1;
        total++;
        if (REQ_READY !== 4'b0001) begin
            bad++;
            $display("FAIL release_ready: got %b want 0001", REQ_READY);
        end
        edge1();
        total++;
        if ({WB_VALID, WB_RD, WB_DATA} !== {1'b1, 5'd6, 32'h66}) begin
            bad++;
            $display("FAIL release_beat: got v=%b rd=%0d data=%h, want 1/6/66", WB_VALID, WB_RD, WB_DATA);
        end
        clear_inputs();
    endtask

    task automatic test_rd_zero();
        clear_inputs();
        do_flush();
        set_req(1, 1'b1, 5'd0, 32'h55);
        #1;
        total++;
        if (REQ_READY !== 4'b0010) begin
            bad++;
            $display("FAIL rd0_ready: got %b want 0010", REQ_READY);
        end
        edge1();
        total++;
        if (WB_VALID !== 1'b0) begin
            bad++;
            $display("FAIL rd0_no_beat: got valid %b want 0", WB_VALID);
        end
        for (int i = 0; i < P; i++) set_req(i, 1'b1, 5'(i + 20), 32'(i));
        #1;
        total++;
        if (REQ_READY !== 4'b0100) begin
            bad++;
            $display("FAIL rd0_ptr_advance: got %b want 0100", REQ_READY);
        end
        edge1();
        total++;
        if ({WB_VALID, WB_SRC} !== {1'b1, 2'd2}) begin
            bad++;
            $display("FAIL rd0_next_src: got v=%b src=%0d, want v=1 src=2", WB_VALID, WB_SRC);
        end
        clear_inputs();
    endtask

    task automatic test_flush();
        clear_inputs();
        do_flush();
        set_req(2, 1'b1, 5'd7, 32'h77);
        edge1();
        set_req(2, 1'b0, 5'd0, 32'h0);
        set_req(0, 1'b1, 5'd9, 32'h99);
        set_req(3, 1'b1, 5'd10, 32'hAA);
        FLUSH = 1'b1;
        #1;
        total++;
        if (REQ_READY !== 4'b0000) begin
            bad++;
            $display("FAIL flush_ready: got %b want 0000", REQ_READY);
        end
        edge1();
        total++;
        if ({WB_VALID, WB_RD, WB_DATA, WB_SRC} !== 40'd0) begin
            bad++;
            $display("FAIL flush_outputs: got v=%b rd=%0d data=%h src=%0d, want all zero", WB_VALID, WB_RD, WB_DATA, WB_SRC);
        end
        FLUSH = 1'b0;
        #1;
        total++;
        if (REQ_READY !== 4'b0001) begin
            bad++;
            $display("FAIL flush_ptr_zero: got %b want 0001", REQ_READY);
        end
        clear_inputs();
        edge1();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        do_flush();
        set_req(1, 1'b1, 5'd12, 32'hABC);
        edge1();
        total++;
        if (WB_VALID !== 1'b1) begin
            bad++;
            $display("FAIL areset_setup: got valid %b want 1", WB_VALID);
        end
        set_req(1, 1'b0, 5'd0, 32'h0);
        set_req(0, 1'b1, 5'd13, 32'h13);
        set_req(3, 1'b1, 5'd14, 32'h14);
        WB_READY = 1'b0;
        #2 RST = 1'b0;
        #1;
        total++;
        if ({WB_VALID, WB_RD, WB_DATA, WB_SRC} !== 40'd0) begin
            bad++;
            $display("FAIL areset_immediate: got v=%b rd=%0d data=%h src=%0d, want all zero", WB_VALID, WB_RD, WB_DATA, WB_SRC);
        end
        total++;
        if (REQ_READY !== 4'b0000) begin
            bad++;
            $display("FAIL areset_ready: got %b want 0000", REQ_READY);
        end
        #2 RST = 1'b1;
        WB_READY = 1'b1;
        #1;
        total++;
        if (REQ_READY !== 4'b0001) begin
            bad++;
            $display("FAIL areset_ptr: got %b want 0001", REQ_READY);
        end
        edge1();
        total++;
        if ({WB_VALID, WB_SRC, WB_RD} !== {1'b1, 2'd0, 5'd13}) begin
            bad++;
            $display("FAIL areset_first_grant: got v=%b src=%0d rd=%0d, want 1/0/13", WB_VALID, WB_SRC, WB_RD);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int         g;
        logic [3:0] one;
        logic [3:0] exp_rdy;
        one = 4'b0001;
        clear_inputs();
        FLUSH = 1'b1;
        @(posedge CLK);
        model_step();
        #1;
        FLUSH = 1'b0;
        for (int c = 0; c < 400; c++) begin
            REQ_VALID = 4'($urandom_range(0, 15));
            for (int i = 0; i < P; i++) begin
                REQ_RD[5*i +: 5]     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                REQ_DATA[32*i +: 32] = $urandom;
            end
            WB_READY = ($urandom_range(0, 3) != 0);
            FLUSH    = ($urandom_range(0, 31) == 0);
            #1;
            g = model_pick();
            exp_rdy = (g >= 0) ? (one << g) : 4'b0000;
            total++;
            if (REQ_READY !== exp_rdy) begin
                bad++;
                $display("FAIL rand_ready[%0d]: got %b want %b", c, REQ_READY, exp_rdy);
            end
            @(posedge CLK);
            model_step();
            #1;
            total++;
            if (WB_VALID !== m_valid) begin
                bad++;
                $display("FAIL rand_valid[%0d]: got %b want %b", c, WB_VALID, m_valid);
            end else if (m_valid && ({WB_RD, WB_DATA, WB_SRC} !== {m_rd, m_data, 2'(m_src)})) begin
                bad++;
                $display("FAIL rand_beat[%0d]: got rd=%0d data=%h src=%0d, want rd=%0d data=%h src=%0d", c, WB_RD, WB_DATA, WB_SRC, m_rd, m_data, m_src);
            end
        end
        clear_inputs();
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        test_reset();
        test_two_requesters();
        test_round_robin();
        test_backpressure();
        test_rd_zero();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter COP_NUMS, default 1, number of coprocessor requesters.
REQ-002 Parameter PNUMS, default COP_NUMS+1, total requesters; index 0 = main pipeline, index 1..COP_NUMS = coprocessors.
REQ-003 CLK  in  1  sole clock, all state on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-low (0 = reset).
REQ-005 FLUSH  in  1  pipeline flush, synchronous, active-high.
REQ-006 REQ_VALID  in  PNUMS  per-requester write-back request.
REQ-007 REQ_RD  in  5*PNUMS  per-requester destination register, slice i = bits [5i+4:5i].
REQ-008 REQ_DATA  in  32*PNUMS  per-requester write data, slice i = bits [32i+31:32i].
REQ-009 REQ_READY  out  PNUMS  per-requester accept; one-hot or zero.
REQ-010 WB_VALID  out  1  register-file write beat pending.
REQ-011 WB_RD  out  5  destination register of pending beat.
REQ-012 WB_DATA  out  32  data of pending beat.
REQ-013 WB_SRC  out  clog2(PNUMS) (min 1)  index of requester that produced pending beat.
REQ-014 WB_READY  in  1  register file accepts pending beat.

Function
REQ-015 Transfer on requester i occurs in a cycle where REQ_VALID[i] and REQ_READY[i] are both 1.
REQ-016 Slot free = !WB_VALID || WB_READY; REQ_READY is all-zero when slot not free or FLUSH=1.
REQ-017 When slot free, grant exactly one valid requester, chosen round-robin: first valid index scanning upward from pointer PTR, wrapping PNUMS-1 -> 0.
REQ-018 REQ_READY is combinational from REQ_VALID, PTR, WB_VALID, WB_READY, FLUSH; it never depends on REQ_RD/REQ_DATA.
REQ-019 On transfer from i: next cycle WB_VALID=1, WB_RD/WB_DATA = granted slice, WB_SRC=i; latency exactly 1 cycle.
REQ-020 On transfer from i: PTR <= (i+1) mod PNUMS; no transfer -> PTR unchanged.
REQ-021 Beat with REQ_RD=0 is accepted (REQ_READY=1) but produces no beat: WB_VALID stays/becomes 0 after a simultaneous drain; PTR still advances.
REQ-022 WB_VALID=1 and WB_READY=0: WB_VALID/WB_RD/WB_DATA/WB_SRC hold unchanged, no grant.
REQ-023 WB_VALID=1 and WB_READY=1 with no new transfer: WB_VALID <= 0 next cycle.
REQ-024 Drain and new transfer in same cycle: back-to-back beats, no bubble (throughput 1 beat/cycle).
REQ-025 FLUSH=1: next cycle WB_VALID=0, WB_RD=0, WB_DATA=0, WB_SRC=0, PTR=0; pending beat discarded even if WB_READY=1 that cycle.
REQ-026 FLUSH has priority over any concurrent grant or drain.
REQ-027 Requester whose REQ_VALID drops before grant is simply skipped; no state retained per requester.
REQ-028 Starvation bound: continuously valid requester is granted within PNUMS transfers.

Reset
REQ-029 RST=0 asynchronously forces WB_VALID=0, WB_RD=0, WB_DATA=0, WB_SRC=0, PTR=0; REQ_READY=0 while RST=0.
REQ-030 First grant possible on first rising CLK edge after RST deasserts; reset mid-beat discards the beat.

Structure
REQ-031 Shared package holds: requester index constant MAIN_IDX=0, register index width 5, data width 32, clog2 function for WB_SRC/PTR width.
REQ-032 One sub-module rr_arbiter (parameter N; inputs req[N], ptr, en; outputs grant one-hot, grant index), purely combinational; wb_arbiter owns all state.

Verification
REQ-033 COP_NUMS=1, main and cop valid together, PTR=0, WB_READY=1 -> main granted (RD=3,DATA=0x11 appears next cycle, WB_SRC=0), then cop (RD=4,DATA=0x22, WB_SRC=1) the following cycle, no bubble.
REQ-034 COP_NUMS=3, all four valid continuously, WB_READY=1 -> WB_SRC sequence 0,1,2,3,0 over 5 cycles.
REQ-035 WB_READY=0 for 3 cycles with beat RD=5,DATA=0xDEADBEEF pending -> outputs held, REQ_READY=0 all 3 cycles; WB_READY=1 -> next queued beat appears one cycle later.
REQ-036 Cop request RD=0,DATA=0x55 -> REQ_READY[1]=1, WB_VALID stays 0, PTR advances to next index.
REQ-037 FLUSH asserted with pending beat and main valid -> no grant that cycle, next cycle WB_VALID=0, WB_SRC=0, PTR=0.
REQ-038 RST driven low between clock edges with WB_VALID=1 -> WB_VALID=0 immediately, before next CLK edge.
